// File: rtl/axis_bk_arbiter_if.sv
// Requester/backend bundle shared by the round-robin backend arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface axis_bk_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 2,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ*USER_WIDTH-1:0] req_user;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         bk_data;
    logic [USER_WIDTH-1:0]         bk_user;
    logic                          bk_valid;
    logic                          bk_ready;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    modport slave (
        input  req_data, req_user, req_valid, bk_ready,
        output req_ready, bk_data, bk_user, bk_valid, grant_id, busy
    );

    modport master (
        output req_data, req_user, req_valid, bk_ready,
        input  req_ready, bk_data, bk_user, bk_valid, grant_id, busy
    );
endinterface

// File: rtl/axis_bk_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream master backend among NUM_REQ requesters.
// Exactly one grant is held per transfer, and the grant is released on the master's bk_ready pulse.
module axis_bk_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 2,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic              axi_aclk,
    input logic              axi_areset,
    axis_bk_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] grant_q;
    logic                valid_q;

    logic                found;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH-1:0] next_ptr;
    logic [NUM_REQ-1:0]  ready;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    assign next_ptr = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + ID_WIDTH'(1);

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= winner;
                        valid_q <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    // Requester valid is not re-checked; only bk_ready releases the grant
                    if (bus.bk_ready) begin
                        rr_ptr  <= next_ptr;
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Completion pulse routed only to the granted requester, in the bk_ready cycle itself
    always_comb begin
        ready = '0;
        if (state == GRANT && bus.bk_ready) begin
            ready[grant_q] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign bus.bk_data   = (state == GRANT) ? bus.req_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.bk_user   = (state == GRANT) ? bus.req_user[32'(grant_q)*USER_WIDTH +: USER_WIDTH] : '0;
    assign bus.bk_valid  = valid_q;
    assign bus.busy      = valid_q;
    assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_axis_bk_arbiter.sv
// Directed self-checking bench for axis_bk_arbiter: single request, rotation, wrap-around,
// stray bk_ready, mid-grant reset and early valid drop.
module tb_axis_bk_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned USER_WIDTH = 2;
    localparam int unsigned ID_WIDTH   = 2;

    logic axi_aclk;
    logic axi_areset;
    int   checks;
    int   errors;

    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];
    logic [USER_WIDTH-1:0] lane_user [NUM_REQ];

    axis_bk_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    axis_bk_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_areset (axi_areset),
        .bus        (bus)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic load_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_data[i];
            bus.req_user[i*USER_WIDTH +: USER_WIDTH] = lane_user[i];
        end
    endtask

    // Called one step after the edge that entered GRANT; ends in the following bubble cycle
    task automatic transfer(input int id);
        logic [NUM_REQ-1:0] onehot;
        onehot     = '0;
        onehot[id] = 1'b1;
        check("grant_valid", bus.bk_valid, 1'b1);
        check("grant_id", bus.grant_id, id);
        check("grant_data", bus.bk_data, lane_data[id]);
        check("grant_user", bus.bk_user, lane_user[id]);
        check("ready_before", bus.req_ready, '0);
        bus.bk_ready = 1'b1;
        #1;
        check("ready_pulse", bus.req_ready, onehot);
        tick();
        bus.bk_ready = 1'b0;
        #1;
        check("bubble_valid", bus.bk_valid, 1'b0);
        check("bubble_ready", bus.req_ready, '0);
        check("bubble_data", bus.bk_data, '0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        axi_areset     = 1'b1;
        bus.req_valid  = '0;
        bus.bk_ready   = 1'b0;
        lane_data[0]   = 32'h1000_00A0;
        lane_data[1]   = 32'h2000_00B1;
        lane_data[2]   = 32'hDEAD_BEEF;
        lane_data[3]   = 32'h4000_00D3;
        lane_user[0]   = 2'b10;
        lane_user[1]   = 2'b11;
        lane_user[2]   = 2'b01;
        lane_user[3]   = 2'b00;
        load_lanes();

        // Reset state
        tick();
        tick();
        check("rst_valid", bus.bk_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", bus.grant_id, 2'd0);
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_data", bus.bk_data, 32'h0);
        check("rst_user", bus.bk_user, 2'b00);
        check("rst_ptr", dut.rr_ptr, 2'd0);
        axi_areset = 1'b0;

        // Single request on lane 2, master answers 3 cycles after bk_valid
        tick();
        bus.req_valid = 4'b0100;
        #1;
        check("single_pre_valid", bus.bk_valid, 1'b0);
        tick();
        check("single_valid", bus.bk_valid, 1'b1);
        check("single_busy", bus.busy, 1'b1);
        check("single_data", bus.bk_data, 32'hDEAD_BEEF);
        check("single_user", bus.bk_user, 2'b01);
        check("single_grant", bus.grant_id, 2'd2);
        tick();
        check("single_hold1", bus.bk_valid, 1'b1);
        tick();
        check("single_hold2", bus.bk_valid, 1'b1);
        tick();
        transfer(2);
        bus.req_valid = 4'b0000;
        check("single_ptr", dut.rr_ptr, 2'd3);
        check("single_grant_hold", bus.grant_id, 2'd2);
        check("single_busy_low", bus.busy, 1'b0);

        // Rotation from a fresh reset: all four continuously valid
        axi_areset = 1'b1;
        #1;
        axi_areset = 1'b0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            transfer(k % 4);
        end
        bus.req_valid = 4'b0000;
        check("rot_ptr", dut.rr_ptr, 2'd1);

        // Wrap-around: grant 3 sets rr_ptr to 0, then 1010 gives 1 then 3
        tick();
        bus.req_valid = 4'b1000;
        tick();
        transfer(3);
        bus.req_valid = 4'b0000;
        check("wrap_ptr", dut.rr_ptr, 2'd0);
        tick();
        bus.req_valid = 4'b1010;
        tick();
        transfer(1);
        bus.req_valid = 4'b1000;
        tick();
        transfer(3);
        bus.req_valid = 4'b0000;

        // Stray bk_ready in IDLE
        tick();
        bus.bk_ready = 1'b1;
        #1;
        check("stray_ready", bus.req_ready, 4'b0000);
        check("stray_valid", bus.bk_valid, 1'b0);
        tick();
        bus.bk_ready = 1'b0;
        #1;
        check("stray_valid_after", bus.bk_valid, 1'b0);
        check("stray_busy", bus.busy, 1'b0);
        check("stray_ptr", dut.rr_ptr, 2'd0);
        check("stray_grant", bus.grant_id, 2'd3);

        // Reset while granted, before bk_ready
        bus.req_valid = 4'b0100;
        tick();
        check("mid_busy", bus.busy, 1'b1);
        check("mid_grant", bus.grant_id, 2'd2);
        axi_areset   = 1'b1;
        bus.bk_ready = 1'b1;
        #1;
        check("mid_rst_valid", bus.bk_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_ready", bus.req_ready, 4'b0000);
        check("mid_rst_grant", bus.grant_id, 2'd0);
        check("mid_rst_ptr", dut.rr_ptr, 2'd0);
        bus.bk_ready  = 1'b0;
        bus.req_valid = 4'b0001;
        tick();
        axi_areset = 1'b0;
        tick();
        transfer(0);

        // Early valid drop by granted requester 1; next search starts at 2
        bus.req_valid = 4'b0011;
        tick();
        check("drop_grant", bus.grant_id, 2'd1);
        bus.req_valid = 4'b1001;
        tick();
        check("drop_hold_valid", bus.bk_valid, 1'b1);
        tick();
        transfer(1);
        check("drop_ptr", dut.rr_ptr, 2'd2);
        tick();
        transfer(3);
        bus.req_valid = 4'b0000;
        tick();
        check("final_idle", bus.bk_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
